// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared ternary encodings, FSM states and threshold helper for neuron back-ends
package tnn_pkg;

  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Signed compare of a sign-extended total against an inclusive dead band [lo, hi].
  function automatic logic [1:0] ternary_thresh(input int total, input int hi, input int lo);
    if (total > hi)      return ACT_POS;
    else if (total < lo) return ACT_NEG;
    else                 return ACT_ZERO;
  endfunction

endpackage

// File: rtl/tnn_ternary_thresh.sv
// rtl/tnn_ternary_thresh.sv - combinational signed total to ternary activation code
module tnn_ternary_thresh
  import tnn_pkg::*;
#(
  parameter int ACC_W  = 10,
  parameter int THR_HI = 3,
  parameter int THR_LO = -3
) (
  input  logic [ACC_W-1:0] total,
  output logic [1:0]       act
);

  logic signed [ACC_W-1:0] total_s;
  int                      total_ext;

  assign total_s   = total;
  assign total_ext = int'(total_s);
  assign act       = ternary_thresh(total_ext, THR_HI, THR_LO);

endmodule

// File: rtl/tnn_neuron_accum.sv
// rtl/tnn_neuron_accum.sv - accumulates per-chunk popcount differences and emits a ternary activation
module tnn_neuron_accum
  import tnn_pkg::*;
#(
  parameter int MAX_CHUNKS = 16,
  parameter int ACC_W      = 10,
  parameter int THR_HI     = 3,
  parameter int THR_LO     = -3,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [CNT_W-1:0] pos_cnt,
  input  logic [CNT_W-1:0] neg_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_act,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CC_W = $clog2(MAX_CHUNKS + 1);

  if ((2 ** (ACC_W - 1)) - 1 < 31 * MAX_CHUNKS) begin : g_acc_w_chk
    $error("ACC_W too narrow for 31*MAX_CHUNKS");
  end
  if (THR_LO > THR_HI) begin : g_thr_chk
    $error("THR_LO must not exceed THR_HI");
  end

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, delta, total;
  logic [CC_W-1:0]         chunk_cnt, cnt_base;
  logic                    accept, hit_max, finish;
  logic [1:0]              act_nxt;

  assign in_ready  = (state != ST_DONE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;

  // Modular subtraction of zero-extended counts yields the correct two's-complement delta.
  assign delta    = ACC_W'(pos_cnt) - ACC_W'(neg_cnt);
  assign total    = (state == ST_ACCUM) ? acc + delta : delta;
  assign cnt_base = (state == ST_ACCUM) ? chunk_cnt : '0;
  assign hit_max  = (cnt_base + CC_W'(1)) == CC_W'(MAX_CHUNKS);
  assign finish   = accept & (in_last | hit_max);

  tnn_ternary_thresh #(
    .ACC_W  (ACC_W),
    .THR_HI (THR_HI),
    .THR_LO (THR_LO)
  ) u_thresh (
    .total (total),
    .act   (act_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACCUM: if (accept) state_nxt = finish ? ST_DONE : ST_ACCUM;
      ST_DONE:           if (out_ready) state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      chunk_cnt <= '0;
      out_act   <= ACT_ZERO;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (finish) begin
        out_act   <= act_nxt;
        out_sum   <= total;
        // finish without in_last can only mean the chunk limit was reached
        out_ovf   <= ~in_last;
        acc       <= '0;
        chunk_cnt <= '0;
      end else begin
        acc       <= total;
        chunk_cnt <= cnt_base + CC_W'(1);
      end
    end else if (state == ST_DONE && out_ready) begin
      acc       <= '0;
      chunk_cnt <= '0;
      out_ovf   <= 1'b0;
    end
  end

endmodule

// File: doc/tnn_neuron_accum.md
Name: tnn_neuron_accum

Overview:
- Sequential neuron back-end sitting directly downstream of the popcount22 stage in the printed ternary-neuron datapath.
- Consumes per-chunk popcounts of positively-weighted and negatively-weighted input hits from two popcount22 instances.
- Accumulates the signed difference over up to MAX_CHUNKS 22-input chunks, then thresholds the total into a ternary activation {-1, 0, +1}.
- Result is delivered over a valid/ready handshake.

Parameters:
- MAX_CHUNKS, 16: maximum chunks per neuron evaluation; a forced terminate occurs at this count.
- ACC_W, 10: signed accumulator width. Must satisfy 2^(ACC_W-1)-1 >= 31*MAX_CHUNKS, so no overflow is possible.
- THR_HI, 3: signed; total > THR_HI gives +1.
- THR_LO, -3: signed; total < THR_LO gives -1. Must satisfy THR_LO <= THR_HI.
- CNT_W, 5: popcount input width (22 -> 5 bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  chunk popcounts valid.
- in_ready  out  1  block can accept a chunk.
- in_last  in  1  current chunk is the final one of this neuron.
- pos_cnt  in  CNT_W  popcount of +1-weighted active inputs. Unsigned; values up to 31 are accepted unclamped because upstream is approximate, WCE 1.
- neg_cnt  in  CNT_W  popcount of -1-weighted active inputs. Unsigned.
- out_valid  out  1  activation valid.
- out_ready  in  1  consumer accepts activation.
- out_act  out  2  ternary activation: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0. 2'b10 is never driven.
- out_sum  out  ACC_W  signed final accumulated total, for debug and verification.
- out_ovf  out  1  evaluation was terminated by MAX_CHUNKS without in_last.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; acc = 0; chunk_cnt = 0.
  - out_valid = 0; out_act = 2'b00; out_sum = 0; out_ovf = 0; in_ready = 1.
  - Any in-flight evaluation is discarded.
- Accept event: in_valid & in_ready. delta = zero-extend(pos_cnt) - zero-extend(neg_cnt), sign-extended to ACC_W.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE (in_ready = 1):
    - Accept with in_last = 1 -> DONE; total = delta.
    - Accept with in_last = 0 -> ACCUM; acc = delta; chunk_cnt = 1.
    - No accept -> stay in IDLE.
  - ACCUM (in_ready = 1):
    - Accept: total = acc + delta; chunk_cnt increments.
    - If in_last = 1, or chunk_cnt + 1 == MAX_CHUNKS -> DONE.
    - out_ovf is set only when terminating on MAX_CHUNKS with in_last = 0.
    - No accept -> hold acc and chunk_cnt; no timeout.
  - DONE (in_ready = 0, out_valid = 1):
    - out_act, out_sum and out_ovf are registered on the DONE entry edge and held stable while out_ready = 0.
    - out_valid & out_ready -> IDLE; acc = 0, chunk_cnt = 0, out_valid = 0, out_ovf = 0.
    - out_act and out_sum may keep their stale values after leaving DONE.
- Threshold rule, applied to total on the DONE entry edge:
  - total > THR_HI -> +1.
  - total < THR_LO -> -1.
  - otherwise -> 0.
  - Comparisons are signed, ACC_W wide.
- Latency: out_valid rises on the clock edge that accepts the final chunk, i.e. visible in the next cycle.
- Throughput: a single-chunk neuron needs 2 cycles with out_ready held high (accept, then hand off). There is no back-to-back overlap; in_ready stays low during DONE.
- Inputs while in_ready = 0 are ignored. Upstream must hold its data until in_ready is asserted.
- pos_cnt == neg_cnt gives delta 0. An all-zero neuron yields total 0 -> act 0 (with defaults).
- No saturation logic; the ACC_W constraint guarantees range. Implementation includes an elaboration-time check of the width constraint and of THR_LO <= THR_HI.

Decomposition:
- Shared package tnn_pkg holds:
  - ternary encoding constants ACT_POS, ACT_NEG, ACT_ZERO;
  - the FSM state enum;
  - a function ternary_thresh(total, hi, lo).
- One natural sub-module: tnn_ternary_thresh, a combinational signed compare to a 2-bit code. It is reusable by other neuron variants. The FSM, accumulator and counter stay in the top module.

Test Plan:
- Reset mid-ACCUM: 3 chunks (pos=10, neg=2), then pull rst_n low asynchronously between edges -> out_valid, acc and chunk_cnt are 0 immediately; the next 1-chunk evaluation (pos=5, neg=0) gives out_act = 01, out_sum = 5.
- Single chunk, three cases, each with in_last = 1:
  - pos=22, neg=0 -> out_act = 01, out_sum = 22, 1-cycle latency.
  - pos=0, neg=22 -> out_act = 11, out_sum = -22.
  - pos=7, neg=5 -> out_act = 00, out_sum = 2.
- Threshold boundaries across 2 chunks:
  - totals of exactly 3 -> act 00; 4 -> 01.
  - totals of exactly -3 -> act 00; -4 -> 11.
- MAX_CHUNKS overflow: 16 chunks of pos=31, neg=0, all with in_last = 0 -> DONE after the 16th accept; out_sum = 496, out_act = 01, out_ovf = 1; in_ready = 0 for the following cycles.
- Output backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_* stable, in_ready = 0, a presented chunk is not consumed; the out_ready pulse returns the FSM to IDLE and the held chunk is then accepted.
- Input bubbles: 4 chunks with in_valid gaps of 0–3 cycles, (pos, neg) = (1,9), (2,8), (3,7), (0,0, last) -> out_sum = -18, out_act = 11, out_ovf = 0.
